// File: rtl/projectile_fire_controller_if.sv
// Fire-control bundle between the archer datapath/game logic and the projectile
// fire controller. The controller takes the slave side.
interface projectile_fire_controller_if #(
  parameter int PROJECTILE_COUNT = 4,
  parameter int MAG_SIZE         = 8
);
  logic                                frame_tick;
  logic [1:0]                          game_active;
  logic                                alive;
  logic                                mouse_clicked;
  logic [PROJECTILE_COUNT-1:0]         slot_free;
  logic                                fire_ack;
  logic                                fire_req;
  logic [$clog2(PROJECTILE_COUNT)-1:0] fire_slot;
  logic [$clog2(MAG_SIZE+1)-1:0]       ammo;
  logic                                reloading;
  logic                                fire_fail;

  modport slave (
    input  frame_tick, game_active, alive, mouse_clicked, slot_free, fire_ack,
    output fire_req, fire_slot, ammo, reloading, fire_fail
  );

  modport master (
    output frame_tick, game_active, alive, mouse_clicked, slot_free, fire_ack,
    input  fire_req, fire_slot, ammo, reloading, fire_fail
  );
endinterface

// File: rtl/projectile_fire_controller.sv
// Fire controller: issues slot launch requests, tracks the magazine, and
// enforces the per-shot cooldown and reload delay (both counted in frame ticks).
module projectile_fire_controller #(
  parameter int PROJECTILE_COUNT = 4,
  parameter int MAG_SIZE         = 8,
  parameter int FIRE_COOLDOWN    = 25,
  parameter int RELOAD_FRAMES    = 90,
  parameter int ACK_TIMEOUT      = 16
) (
  input  logic clk,
  input  logic rst,
  projectile_fire_controller_if.slave bus
);
  localparam int SW  = $clog2(PROJECTILE_COUNT);
  localparam int AW  = $clog2(MAG_SIZE + 1);
  localparam int CCW = $clog2(FIRE_COOLDOWN + 1);
  localparam int RCW = $clog2(RELOAD_FRAMES + 1);
  localparam int TW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [AW-1:0]  AMMO_FULL   = AW'(MAG_SIZE);
  localparam logic [CCW-1:0] COOL_LOAD   = CCW'(FIRE_COOLDOWN);
  localparam logic [RCW-1:0] RELOAD_LOAD = RCW'(RELOAD_FRAMES);
  localparam logic [TW-1:0]  ACK_LAST    = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COOLDOWN, S_RELOAD} state_t;

  state_t         r_state,      w_state_nxt;
  logic [SW-1:0]  r_slot,       w_slot_nxt;
  logic [AW-1:0]  r_ammo,       w_ammo_nxt;
  logic [CCW-1:0] r_cool_cnt,   w_cool_nxt;
  logic [RCW-1:0] r_reload_cnt, w_reload_nxt;
  logic [TW-1:0]  r_ack_cnt,    w_ack_nxt;
  logic           r_fail,       w_fail_nxt;

  logic           w_enabled;
  logic [SW-1:0]  w_low_slot;

  assign w_enabled = (bus.game_active == 2'd1) && bus.alive;

  // Lowest-index free slot wins; scanning high-to-low lets the last hit stick.
  always_comb begin
    w_low_slot = '0;
    for (int i = PROJECTILE_COUNT - 1; i >= 0; i--) begin
      if (bus.slot_free[i]) w_low_slot = SW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_ammo       <= AMMO_FULL;
      r_cool_cnt   <= '0;
      r_reload_cnt <= '0;
      r_ack_cnt    <= '0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_ammo       <= w_ammo_nxt;
      r_cool_cnt   <= w_cool_nxt;
      r_reload_cnt <= w_reload_nxt;
      r_ack_cnt    <= w_ack_nxt;
      r_fail       <= w_fail_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_ammo_nxt   = r_ammo;
    w_cool_nxt   = r_cool_cnt;
    w_reload_nxt = r_reload_cnt;
    w_ack_nxt    = r_ack_cnt;
    w_fail_nxt   = 1'b0;

    // Losing "enabled" overrides everything, including an ack in the same cycle.
    if (!w_enabled) begin
      w_state_nxt  = S_IDLE;
      w_ammo_nxt   = AMMO_FULL;
      w_cool_nxt   = '0;
      w_reload_nxt = '0;
      w_ack_nxt    = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.mouse_clicked && (r_ammo != '0) && (|bus.slot_free)) begin
            w_state_nxt = S_REQ;
            w_slot_nxt  = w_low_slot;
            w_ack_nxt   = '0;
          end
        end
        S_REQ: begin
          if (bus.fire_ack) begin
            w_state_nxt = S_COOLDOWN;
            w_ammo_nxt  = (r_ammo != '0) ? r_ammo - AW'(1) : '0;
            w_cool_nxt  = COOL_LOAD;
            w_ack_nxt   = '0;
          end else if (r_ack_cnt >= ACK_LAST) begin
            w_state_nxt = S_IDLE;
            w_fail_nxt  = 1'b1;
            w_ack_nxt   = '0;
          end else begin
            w_ack_nxt = r_ack_cnt + TW'(1);
          end
        end
        S_COOLDOWN: begin
          if (bus.frame_tick && (r_cool_cnt != '0)) w_cool_nxt = r_cool_cnt - CCW'(1);
          if ((r_cool_cnt == '0) || (bus.frame_tick && (r_cool_cnt == CCW'(1)))) begin
            if (r_ammo == '0) begin
              w_state_nxt  = S_RELOAD;
              w_reload_nxt = RELOAD_LOAD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_RELOAD: begin
          if (bus.frame_tick && (r_reload_cnt != '0)) w_reload_nxt = r_reload_cnt - RCW'(1);
          if ((r_reload_cnt == '0) || (bus.frame_tick && (r_reload_cnt == RCW'(1)))) begin
            w_state_nxt = S_IDLE;
            w_ammo_nxt  = AMMO_FULL;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Request and reload flags decode straight from the state so reset drops them at once.
  assign bus.fire_req  = (r_state == S_REQ);
  assign bus.reloading = (r_state == S_RELOAD);
  assign bus.fire_slot = r_slot;
  assign bus.ammo      = r_ammo;
  assign bus.fire_fail = r_fail;
endmodule

// File: tb/tb_projectile_fire_controller.sv
// Directed bench for projectile_fire_controller: inputs change on the falling
// edge, outputs are sampled on the falling edge before any new drive.
module tb_projectile_fire_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  projectile_fire_controller_if #(.PROJECTILE_COUNT(4), .MAG_SIZE(8)) bif ();

  projectile_fire_controller #(
    .PROJECTILE_COUNT(4), .MAG_SIZE(8), .FIRE_COOLDOWN(25),
    .RELOAD_FRAMES(90), .ACK_TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic frame();
    bif.frame_tick = 1'b1;
    step();
    bif.frame_tick = 1'b0;
    step();
  endtask

  task automatic restore();
    bif.mouse_clicked = 1'b0;
    bif.fire_ack      = 1'b0;
    bif.frame_tick    = 1'b0;
    bif.game_active   = 2'd1;
    bif.alive         = 1'b0;
    step();
    bif.alive = 1'b1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (bif.fire_req !== 1'b0) begin bad++; $display("FAIL reset_fire_req: got %b want 0", bif.fire_req); end
    total++; if (bif.fire_slot !== 2'd0) begin bad++; $display("FAIL reset_fire_slot: got %0d want 0", bif.fire_slot); end
    total++; if (bif.ammo !== 4'd8) begin bad++; $display("FAIL reset_ammo: got %0d want 8", bif.ammo); end
    total++; if (bif.reloading !== 1'b0) begin bad++; $display("FAIL reset_reloading: got %b want 0", bif.reloading); end
    total++; if (bif.fire_fail !== 1'b0) begin bad++; $display("FAIL reset_fire_fail: got %b want 0", bif.fire_fail); end
    rst = 1'b0;
  endtask

  task automatic test_basic_shot();
    int hi;
    restore();
    bif.slot_free = 4'b0110;
    bif.mouse_clicked = 1'b1;
    step();
    bif.mouse_clicked = 1'b0;
    hi = bif.fire_req ? 1 : 0;
    total++; if (bif.fire_slot !== 2'd1) begin bad++; $display("FAIL basic_slot: got %0d want 1", bif.fire_slot); end
    step();
    if (bif.fire_req) hi++;
    bif.fire_ack = 1'b1;
    step();
    bif.fire_ack = 1'b0;
    if (bif.fire_req) hi++;
    total++; if (hi !== 2) begin bad++; $display("FAIL basic_req_width: got %0d clks want 2", hi); end
    total++; if (bif.ammo !== 4'd7) begin bad++; $display("FAIL basic_ammo: got %0d want 7", bif.ammo); end
    repeat (25) frame();
  endtask

  task automatic test_autofire();
    int rises, gap, rticks;
    bit prev, seen_reload, done;
    restore();
    bif.slot_free = 4'b0001;
    bif.mouse_clicked = 1'b1;
    rises = 0; gap = 0; rticks = 0; prev = 1'b0; seen_reload = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      step();
      if (bif.fire_req && !prev) begin
        rises++;
        if (rises > 1) begin
          total++;
          if (gap !== 25) begin bad++; $display("FAIL autofire_gap shot %0d: got %0d ticks want 25", rises, gap); end
        end
        gap = 0;
      end
      prev = bif.fire_req;
      if (bif.reloading) begin
        seen_reload = 1'b1;
        total++; if (bif.ammo !== 4'd0) begin bad++; $display("FAIL reload_ammo: got %0d want 0", bif.ammo); end
      end
      if (seen_reload && !bif.reloading) begin
        done = 1'b1;
        bif.mouse_clicked = 1'b0;
        total++; if (bif.ammo !== 4'd8) begin bad++; $display("FAIL refill_ammo: got %0d want 8", bif.ammo); end
      end
      bif.fire_ack   = bif.fire_req;
      bif.frame_tick = ((cyc % 4) == 0) && !done;
      if (bif.frame_tick && !bif.fire_req) gap++;
      if (bif.frame_tick && bif.reloading) rticks++;
    end
    bif.mouse_clicked = 1'b0; bif.fire_ack = 1'b0; bif.frame_tick = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL autofire_done: reload end not seen within budget, want seen"); end
    total++; if (rises !== 8) begin bad++; $display("FAIL autofire_shots: got %0d want 8", rises); end
    total++; if (rticks !== 90) begin bad++; $display("FAIL reload_frames: got %0d want 90", rticks); end
  endtask

  task automatic test_timeout();
    int hi, fails, last_hi, fail_at;
    restore();
    bif.slot_free = 4'b0100;
    bif.mouse_clicked = 1'b1;
    step();
    bif.mouse_clicked = 1'b0;
    hi = 0; fails = 0; last_hi = -1; fail_at = -1;
    for (int k = 0; k < 40; k++) begin
      if (bif.fire_req) begin hi++; last_hi = k; end
      if (bif.fire_fail) begin fails++; fail_at = k; end
      step();
    end
    total++; if (hi !== 16) begin bad++; $display("FAIL timeout_req_width: got %0d want 16", hi); end
    total++; if (fails !== 1) begin bad++; $display("FAIL timeout_fail_pulses: got %0d want 1", fails); end
    total++; if (fail_at !== last_hi + 1) begin bad++; $display("FAIL timeout_fail_timing: got %0d want %0d", fail_at, last_hi + 1); end
    total++; if (bif.ammo !== 4'd8) begin bad++; $display("FAIL timeout_ammo: got %0d want 8", bif.ammo); end
    bif.mouse_clicked = 1'b1;
    step();
    bif.mouse_clicked = 1'b0;
    total++; if (bif.fire_req !== 1'b1 || bif.fire_slot !== 2'd2) begin
      bad++; $display("FAIL timeout_idle_refire: got req=%b slot=%0d want req=1 slot=2", bif.fire_req, bif.fire_slot);
    end
    bif.fire_ack = 1'b1;
    step();
    bif.fire_ack = 1'b0;
  endtask

  task automatic test_disable();
    restore();
    bif.slot_free = 4'b0001;
    for (int s = 0; s < 8; s++) begin
      bif.mouse_clicked = 1'b1;
      for (int k = 0; k < 10 && !bif.fire_req; k++) step();
      total++; if (bif.fire_req !== 1'b1) begin bad++; $display("FAIL disable_setup_req shot %0d: got %b want 1", s, bif.fire_req); end
      bif.fire_ack = 1'b1;
      bif.mouse_clicked = 1'b0;
      step();
      bif.fire_ack = 1'b0;
      repeat (25) frame();
    end
    total++; if (bif.reloading !== 1'b1 || bif.ammo !== 4'd0) begin
      bad++; $display("FAIL disable_setup_reload: got reloading=%b ammo=%0d want 1/0", bif.reloading, bif.ammo);
    end
    repeat (10) frame();
    bif.game_active = 2'd2;
    step();
    total++; if (bif.reloading !== 1'b0) begin bad++; $display("FAIL disable_reloading: got %b want 0", bif.reloading); end
    total++; if (bif.ammo !== 4'd8) begin bad++; $display("FAIL disable_ammo: got %0d want 8", bif.ammo); end
    bif.game_active = 2'd1;
    bif.mouse_clicked = 1'b1;
    step();
    total++; if (bif.fire_req !== 1'b1) begin bad++; $display("FAIL disable_req_before_kill: got %b want 1", bif.fire_req); end
    bif.mouse_clicked = 1'b0;
    bif.alive = 1'b0;
    bif.fire_ack = 1'b1;
    step();
    bif.fire_ack = 1'b0;
    bif.alive = 1'b1;
    total++; if (bif.fire_req !== 1'b0) begin bad++; $display("FAIL kill_req: got %b want 0", bif.fire_req); end
    total++; if (bif.ammo !== 4'd8) begin bad++; $display("FAIL kill_ammo: got %0d want 8", bif.ammo); end
    bif.mouse_clicked = 1'b1;
    step();
    bif.mouse_clicked = 1'b0;
    total++; if (bif.fire_req !== 1'b1) begin bad++; $display("FAIL kill_idle_refire: got %b want 1", bif.fire_req); end
    bif.fire_ack = 1'b1;
    step();
    bif.fire_ack = 1'b0;
  endtask

  task automatic test_no_slot();
    int hi;
    restore();
    bif.slot_free = 4'b0000;
    bif.mouse_clicked = 1'b1;
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (bif.fire_req) hi++;
    end
    total++; if (hi !== 0) begin bad++; $display("FAIL noslot_req: got %0d clks high want 0", hi); end
    total++; if (bif.ammo !== 4'd8) begin bad++; $display("FAIL noslot_ammo: got %0d want 8", bif.ammo); end
    bif.slot_free = 4'b1000;
    step();
    bif.mouse_clicked = 1'b0;
    total++; if (bif.fire_req !== 1'b1 || bif.fire_slot !== 2'd3) begin
      bad++; $display("FAIL noslot_release: got req=%b slot=%0d want req=1 slot=3", bif.fire_req, bif.fire_slot);
    end
    bif.fire_ack = 1'b1;
    step();
    bif.fire_ack = 1'b0;
    total++; if (bif.ammo !== 4'd7) begin bad++; $display("FAIL noslot_ammo_after: got %0d want 7", bif.ammo); end
  endtask

  task automatic test_async_reset();
    restore();
    bif.slot_free = 4'b0001;
    bif.mouse_clicked = 1'b1;
    step();
    bif.mouse_clicked = 1'b0;
    step();
    bif.fire_ack = 1'b1;
    step();
    bif.fire_ack = 1'b0;
    bif.mouse_clicked = 1'b1;
    repeat (25) frame();
    step();
    bif.mouse_clicked = 1'b0;
    total++; if (bif.fire_req !== 1'b1 || bif.ammo !== 4'd7) begin
      bad++; $display("FAIL areset_setup: got req=%b ammo=%0d want 1/7", bif.fire_req, bif.ammo);
    end
    #2 rst = 1'b1;
    #1;
    total++; if (bif.fire_req !== 1'b0) begin bad++; $display("FAIL areset_req: got %b want 0 before edge", bif.fire_req); end
    total++; if (bif.ammo !== 4'd8) begin bad++; $display("FAIL areset_ammo: got %0d want 8", bif.ammo); end
    #1 rst = 1'b0;
    step();
    bif.mouse_clicked = 1'b1;
    step();
    bif.mouse_clicked = 1'b0;
    total++; if (bif.fire_req !== 1'b1 || bif.fire_slot !== 2'd0) begin
      bad++; $display("FAIL areset_first_req: got req=%b slot=%0d want 1/0", bif.fire_req, bif.fire_slot);
    end
  endtask

  initial begin
    bif.frame_tick    = 1'b0;
    bif.game_active   = 2'd1;
    bif.alive         = 1'b1;
    bif.mouse_clicked = 1'b0;
    bif.slot_free     = 4'b1111;
    bif.fire_ack      = 1'b0;
    test_reset();
    test_basic_shot();
    test_autofire();
    test_timeout();
    test_disable();
    test_no_slot();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
